// File: rtl/field_render.sv
// Renders a vector-field magnitude map into a framebuffer, one shaded BLOCK_SIZE square per cell.
// Cells and pixels are visited in raster order; framebuffer writes honour draw_ready backpressure.
module field_render #(
   parameter int DRAW_WIDTH   = 640,
   parameter int DRAW_HEIGHT  = 480,
   parameter int DRAW_ADDRW   = $clog2(DRAW_WIDTH*DRAW_HEIGHT),
   parameter int DRAW_DATAW   = 4,
   parameter int FIELD_WIDTH  = 8,
   parameter int FIELD_HEIGHT = 6,
   parameter int FIELD_ADDRW  = $clog2(FIELD_WIDTH*FIELD_HEIGHT),
   parameter int FIELD_DATAW  = 96,
   parameter int BLOCK_SIZE   = 80,
   parameter int MAG_SHIFT    = 24,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   grid_en,
   output logic                   busy,
   output logic                   done,
   output logic [FIELD_ADDRW-1:0] field_addr_read,
   input  logic [FIELD_DATAW-1:0] field_data_out,
   output logic [DRAW_ADDRW-1:0]  draw_addr_write,
   output logic [DRAW_DATAW-1:0]  draw_data_in,
   output logic                   draw_we,
   input  logic                   draw_ready
);

   localparam int LW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int CXW = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;
   localparam int CYW = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;
   localparam int WW  = $clog2(READ_LATENCY + 1);

   localparam logic [LW-1:0]         LAST_L        = LW'(BLOCK_SIZE - 1);
   localparam logic [CXW-1:0]        LAST_CX       = CXW'(FIELD_WIDTH - 1);
   localparam logic [CYW-1:0]        LAST_CY       = CYW'(FIELD_HEIGHT - 1);
   localparam logic [WW-1:0]         WAIT_LOAD     = WW'(READ_LATENCY - 1);
   localparam logic [DRAW_ADDRW-1:0] ROW_STEP      = DRAW_ADDRW'(DRAW_WIDTH);
   localparam logic [DRAW_ADDRW-1:0] COL_STEP      = DRAW_ADDRW'(BLOCK_SIZE);
   localparam logic [DRAW_ADDRW-1:0] CELL_ROW_STEP = DRAW_ADDRW'(BLOCK_SIZE*DRAW_WIDTH);

   if (FIELD_WIDTH*BLOCK_SIZE > DRAW_WIDTH || FIELD_HEIGHT*BLOCK_SIZE > DRAW_HEIGHT) begin : g_fit_check
      $error("field_render: field does not fit the framebuffer");
   end

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PAINT, S_DONE} state_t;

   function automatic logic [DRAW_DATAW-1:0] mag_to_shade(input logic [31:0] mag);
      logic [31:0] upper;
      upper = mag >> (MAG_SHIFT + DRAW_DATAW);
      if (upper != 32'd0) mag_to_shade = '1;
      else                mag_to_shade = mag[MAG_SHIFT +: DRAW_DATAW];
   endfunction

   function automatic logic [DRAW_DATAW-1:0] pixel_value(input logic grid, input logic [LW-1:0] lx,
                                                         input logic [LW-1:0] ly,
                                                         input logic [DRAW_DATAW-1:0] shade);
      if (grid && (lx == '0 || ly == '0)) pixel_value = '0;
      else                                pixel_value = shade;
   endfunction

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d, done_q, done_d, we_q, we_d, grid_q, grid_d;
   logic [FIELD_ADDRW-1:0]  field_addr_q, field_addr_d;
   logic [DRAW_ADDRW-1:0]   draw_addr_q, draw_addr_d;
   logic [DRAW_DATAW-1:0]   draw_data_q, draw_data_d, shade_q, shade_d;
   logic [DRAW_ADDRW-1:0]   row_base_q, row_base_d, cell_base_q, cell_base_d, line_q, line_d;
   logic [CXW-1:0]          cx_q, cx_d;
   logic [CYW-1:0]          cy_q, cy_d;
   logic [LW-1:0]           lx_q, lx_d, ly_q, ly_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic [DRAW_DATAW-1:0]   fetch_shade;
   logic                    unused_field_bits;

   // Only the magnitude word is rendered; the direction components are ignored.
   assign unused_field_bits = ^field_data_out[FIELD_DATAW-1:32];
   assign fetch_shade       = mag_to_shade(field_data_out[31:0]);

   // Next-state and next-output computation for the render sequencer.
   always_comb begin
      state_d = state_q;  busy_d = busy_q;  done_d = done_q;  we_d = we_q;  grid_d = grid_q;
      field_addr_d = field_addr_q;  draw_addr_d = draw_addr_q;  draw_data_d = draw_data_q;
      shade_d = shade_q;  row_base_d = row_base_q;  cell_base_d = cell_base_q;  line_d = line_q;
      cx_d = cx_q;  cy_d = cy_q;  lx_d = lx_q;  ly_d = ly_q;  wait_d = wait_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;  busy_d = 1'b1;  grid_d = grid_en;
               cx_d = '0;  cy_d = '0;  field_addr_d = '0;  row_base_d = '0;  cell_base_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            wait_d = WAIT_LOAD;  lx_d = '0;  ly_d = '0;  state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == '0) begin
               state_d = S_PAINT;  we_d = 1'b1;  shade_d = fetch_shade;
               draw_addr_d = cell_base_q;  line_d = cell_base_q;
               draw_data_d = pixel_value(grid_q, '0, '0, fetch_shade);
            end else begin
               wait_d = wait_q - WW'(1);
            end
         end
         S_PAINT: begin
            if (!draw_ready) begin
               state_d = S_PAINT;
            end else if (lx_q != LAST_L) begin
               lx_d = lx_q + LW'(1);  draw_addr_d = draw_addr_q + DRAW_ADDRW'(1);
               draw_data_d = pixel_value(grid_q, lx_q + LW'(1), ly_q, shade_q);
            end else if (ly_q != LAST_L) begin
               lx_d = '0;  ly_d = ly_q + LW'(1);
               line_d = line_q + ROW_STEP;  draw_addr_d = line_q + ROW_STEP;
               draw_data_d = pixel_value(grid_q, '0, ly_q + LW'(1), shade_q);
            end else if (cx_q == LAST_CX && cy_q == LAST_CY) begin
               we_d = 1'b0;  busy_d = 1'b0;  done_d = 1'b1;  state_d = S_DONE;
            end else begin
               we_d = 1'b0;  state_d = S_FETCH;  field_addr_d = field_addr_q + FIELD_ADDRW'(1);
               // Wrapping to the next cell row restarts from the left edge of that row band.
               if (cx_q != LAST_CX) begin
                  cx_d = cx_q + CXW'(1);  cell_base_d = cell_base_q + COL_STEP;
               end else begin
                  cx_d = '0;  cy_d = cy_q + CYW'(1);
                  row_base_d = row_base_q + CELL_ROW_STEP;  cell_base_d = row_base_q + CELL_ROW_STEP;
               end
            end
         end
         S_DONE: begin
            done_d = 1'b0;  state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;  busy_d = 1'b0;  done_d = 1'b0;  we_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs, with synchronous reset abandoning any frame in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;  we_q <= 1'b0;  grid_q <= 1'b0;
         field_addr_q <= '0;  draw_addr_q <= '0;  draw_data_q <= '0;  shade_q <= '0;
         row_base_q <= '0;  cell_base_q <= '0;  line_q <= '0;
         cx_q <= '0;  cy_q <= '0;  lx_q <= '0;  ly_q <= '0;  wait_q <= '0;
      end else begin
         state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;  we_q <= we_d;  grid_q <= grid_d;
         field_addr_q <= field_addr_d;  draw_addr_q <= draw_addr_d;  draw_data_q <= draw_data_d;
         shade_q <= shade_d;  row_base_q <= row_base_d;  cell_base_q <= cell_base_d;  line_q <= line_d;
         cx_q <= cx_d;  cy_q <= cy_d;  lx_q <= lx_d;  ly_q <= ly_d;  wait_q <= wait_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign draw_we         = we_q;
   assign field_addr_read = field_addr_q;
   assign draw_addr_write = draw_addr_q;
   assign draw_data_in    = draw_data_q;

endmodule

// File: tb/tb_field_render.sv
// Directed bench for field_render on a 16x12 framebuffer with a 4x3 field of 4-pixel cells.
// Expected writes come from a nested-loop model of the visit order and shade rule.
module tb_field_render;
   localparam int DW = 16, DH = 12, FW = 4, FH = 3, BS = 4, RL = 2;
   localparam int NPIX = FW*FH*BS*BS;
   localparam int FRAME_CYC = FW*FH*(BS*BS + 1 + RL);

   logic        clk = 1'b0;
   logic        rst_n, start, grid_en, draw_ready;
   logic        busy, done, draw_we;
   logic [3:0]  field_addr_read;
   logic [95:0] field_data_out;
   logic [7:0]  draw_addr_write;
   logic [3:0]  draw_data_in;

   field_render #(.DRAW_WIDTH(DW), .DRAW_HEIGHT(DH), .DRAW_DATAW(4), .FIELD_WIDTH(FW),
                  .FIELD_HEIGHT(FH), .FIELD_DATAW(96), .BLOCK_SIZE(BS), .MAG_SHIFT(4),
                  .READ_LATENCY(RL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .grid_en(grid_en), .busy(busy), .done(done),
      .field_addr_read(field_addr_read), .field_data_out(field_data_out),
      .draw_addr_write(draw_addr_write), .draw_data_in(draw_data_in), .draw_we(draw_we),
      .draw_ready(draw_ready));

   always #5 clk = ~clk;

   // Field memory with a two-stage read pipeline.
   logic [95:0] mem [16];
   logic [95:0] pipe0, pipe1;
   always @(posedge clk) begin
      pipe0 <= mem[field_addr_read];
      pipe1 <= pipe0;
   end
   assign field_data_out = pipe1;

   int n_chk = 0, n_fail = 0;
   int unsigned mags [12];
   int exp_a [$];
   int exp_d [$];
   int fb [NPIX];
   int hit [NPIX];
   int wr_cnt = 0, done_cnt = 0, ncyc = 0, c0 = 0;
   bit started = 0, ready_rand = 0, prev_stall = 0, prev_done = 0;
   logic [7:0] prev_addr;
   logic [3:0] prev_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, ncyc);
      end
   endtask

   function automatic int model_shade(input int unsigned mag);
      if (mag >= 32'd256) return 15;
      return int'((mag / 16) % 16);
   endfunction

   task automatic load_field();
      for (int i = 0; i < 16; i++)
         mem[i] = {32'hDEADBEEF, 32'hFFFF_FFFF, (i < 12) ? 32'(mags[i]) : 32'd0};
   endtask

   task automatic build_expected(input bit g);
      exp_a.delete();
      exp_d.delete();
      for (int cy = 0; cy < FH; cy++)
         for (int cx = 0; cx < FW; cx++)
            for (int ly = 0; ly < BS; ly++)
               for (int lx = 0; lx < BS; lx++) begin
                  exp_a.push_back((cy*BS + ly)*DW + cx*BS + lx);
                  exp_d.push_back((g && (lx == 0 || ly == 0)) ? 0 : model_shade(mags[cy*FW + cx]));
               end
   endtask

   // Per-cycle compare against the model queue plus handshake and stall checks.
   always @(negedge clk) begin
      ncyc++;
      if (rst_n && start && !busy && !done) begin
         c0 = ncyc;
         started = 1;
      end
      if (started && ncyc == c0 + 1) begin
         chk("busy_after_start", 32'(busy), 32'd1);
         chk("field_addr_first", 32'(field_addr_read), 32'd0);
      end
      if (started && ncyc == c0 + 1 + RL) chk("we_before_first", 32'(draw_we), 32'd0);
      if (started && ncyc == c0 + 2 + RL) chk("we_first", 32'(draw_we), 32'd1);
      if (prev_stall) begin
         chk("stall_we", 32'(draw_we), 32'd1);
         chk("stall_addr", 32'(draw_addr_write), 32'(prev_addr));
         chk("stall_data", 32'(draw_data_in), 32'(prev_data));
      end
      if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
      if (draw_we && draw_ready) begin
         if (exp_a.size() == 0) begin
            chk("unexpected_write", 32'(draw_addr_write), 32'hFFFF_FFFF);
         end else begin
            chk("write_addr", 32'(draw_addr_write), 32'(exp_a.pop_front()));
            chk("write_data", 32'(draw_data_in), 32'(exp_d.pop_front()));
         end
         if (int'(draw_addr_write) < NPIX) begin
            fb[draw_addr_write] = int'(draw_data_in);
            hit[draw_addr_write]++;
         end
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         chk("busy_low_at_done", 32'(busy), 32'd0);
         if (!ready_rand) chk("done_time", 32'(ncyc - c0), 32'(1 + FRAME_CYC));
      end
      prev_stall = rst_n && draw_we && !draw_ready;
      prev_addr  = draw_addr_write;
      prev_data  = draw_data_in;
      prev_done  = rst_n && done;
   end

   // Write-acceptance pattern: always ready, or a random 50% pattern.
   initial begin
      draw_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         draw_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   task automatic start_frame(input bit g);
      build_expected(g);
      for (int i = 0; i < NPIX; i++) begin fb[i] = -1; hit[i] = 0; end
      wr_cnt = 0;
      done_cnt = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      grid_en = g;
      @(posedge clk);
      #1;
      start = 1'b0;
      grid_en = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_cnt == 0 && k < 5000) begin
         @(posedge clk);
         k++;
      end
      chk("done_timeout", 32'(k < 5000), 32'd1);
      repeat (3) @(posedge clk);
   endtask

   task automatic check_frame();
      int bad;
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (hit[i] != 1) bad++;
      chk("write_count", 32'(wr_cnt), 32'(NPIX));
      chk("model_drained", 32'(exp_a.size()), 32'd0);
      chk("coverage_once", 32'(bad), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
   endtask

   task automatic wait_writes(input int n);
      int k;
      k = 0;
      while (wr_cnt < n && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("write_wait_timeout", 32'(k < 2000), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_we"}, 32'(draw_we), 32'd0);
      chk({tag, "_faddr"}, 32'(field_addr_read), 32'd0);
      chk({tag, "_daddr"}, 32'(draw_addr_write), 32'd0);
      chk({tag, "_ddata"}, 32'(draw_data_in), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      grid_en = 1'b0;
      for (int i = 0; i < 12; i++) mags[i] = 32'h35;
      load_field();
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      start = 1'b0;
      rst_n = 1'b1;

      chk("model_shade_35", 32'(model_shade(32'h35)), 32'd3);
      chk("model_shade_100", 32'(model_shade(32'h100)), 32'd15);
      chk("model_shade_20", 32'(model_shade(32'h20)), 32'd2);
      chk("model_shade_f0", 32'(model_shade(32'hF0)), 32'd15);

      // Uniform field.
      start_frame(1'b0);
      wait_done();
      check_frame();
      chk("uniform_px0", 32'(fb[0]), 32'd3);
      chk("uniform_px191", 32'(fb[191]), 32'd3);

      // Saturation in cell 5.
      for (int i = 0; i < 12; i++) mags[i] = 32'h20;
      mags[5] = 32'h100;
      load_field();
      start_frame(1'b0);
      wait_done();
      check_frame();
      chk("sat_px68", 32'(fb[68]), 32'd15);
      chk("sat_px119", 32'(fb[119]), 32'd15);
      chk("sat_px72", 32'(fb[72]), 32'd2);
      chk("sat_px0", 32'(fb[0]), 32'd2);

      // Grid mode.
      for (int i = 0; i < 12; i++) mags[i] = 32'hF0;
      load_field();
      start_frame(1'b1);
      wait_done();
      check_frame();
      chk("grid_px5", 32'(fb[5]), 32'd0);
      chk("grid_px16", 32'(fb[16]), 32'd0);
      chk("grid_px17", 32'(fb[17]), 32'd15);
      chk("grid_px20", 32'(fb[20]), 32'd0);
      chk("grid_px191", 32'(fb[191]), 32'd15);

      // Backpressure with distinct shades per cell.
      for (int i = 0; i < 12; i++) mags[i] = 32'(i*16 + 5);
      load_field();
      ready_rand = 1;
      start_frame(1'b0);
      wait_done();
      ready_rand = 0;
      check_frame();
      chk("bp_px191", 32'(fb[191]), 32'd11);

      // Reset in the middle of a frame, then a fresh frame.
      for (int i = 0; i < 12; i++) mags[i] = 32'h35;
      load_field();
      start_frame(1'b0);
      wait_writes(50);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_a.delete();
      exp_d.delete();
      check_outputs_zero("midreset");
      chk("midreset_no_done", 32'(done_cnt), 32'd0);
      start_frame(1'b0);
      wait_done();
      check_frame();

      // Second start while busy is ignored.
      start_frame(1'b0);
      wait_writes(10);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      check_frame();
      repeat (40) @(posedge clk);
      #1;
      chk("no_second_frame_done", 32'(done_cnt), 32'd1);
      chk("no_second_frame_busy", 32'(busy), 32'd0);
      chk("no_second_frame_writes", 32'(wr_cnt), 32'(NPIX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
